dc_error_mc: RTL and testbench
==============================

Name: dc_error_mc

Overview:
Multi-channel, parametrised DC-error accumulator for time-multiplexed error samples. Each channel sums its signed error samples over a fixed window of 2^WIN_LOG2 samples. At window end it emits the full-precision sum and the rounded mean, tagged with the channel index. It sits between the per-channel error subtractors and the DC-offset correction loop, replacing single-channel accumulators.

Parameters:
IN_W, 18, signed error sample width
NCH, 4, number of channels (>=1)
WIN_LOG2, 10, log2 of samples per window (>=1)
ACC_W, 38, accumulator/sum width; elaboration-time check ACC_W >= IN_W+WIN_LOG2

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
clk_en  in  1  sample strobe; error/ch valid when high
clear_accum  in  1  restart all channel windows, discard partial sums
ch  in  CH_W=max(1,clog2(NCH))  channel of current sample
error  in  IN_W  signed error sample
out_valid  out  1  one-cycle pulse: window result available
out_ch  out  CH_W  channel of result
err_sum  out  ACC_W  signed window sum
err_mean  out  IN_W  signed rounded mean
chan_err  out  1  sticky: sample seen with ch >= NCH

Behaviour:
- Reset: reset is synchronous, active-high; clock is clk. It has top priority and clears all accumulators, per-channel counters, out_valid, out_ch, err_sum, err_mean and chan_err to 0.
- State per channel: acc[c] (ACC_W, signed) and cnt[c] (WIN_LOG2 bits, number of samples held).
- Sample accept: clk_en=1 and ch<NCH. Sign-extend error to ACC_W.
  - If cnt[ch] < 2^WIN_LOG2-1: acc <= acc+error and cnt <= cnt+1.
  - Otherwise this is the final sample. acc <= 0 and cnt <= 0.
  - On the same edge, err_sum <= acc+error, out_ch <= ch and out_valid <= 1.
  - Also on that edge, err_mean <= (acc+error+2^(WIN_LOG2-1)) >>> WIN_LOG2, truncated to IN_W. This is round-half-up, and the result always fits in IN_W.
- Latency: results and out_valid are visible in the cycle after the final-sample edge. out_valid stays high for exactly 1 cycle, then clears. err_sum, err_mean and out_ch hold until the next result. There is no backpressure.
- Bad channel: clk_en=1 and ch >= NCH. The sample is dropped, no state changes, and chan_err <= 1.
- clear_accum=1: all acc and cnt go to 0, chan_err goes to 0, and no result is emitted for partial windows.
  - If clk_en=1 with a valid ch on the same edge, that sample is loaded as the first of a new window: acc[ch] <= error, cnt[ch] <= 1.
  - Output registers (err_sum, err_mean, out_ch) are untouched. out_valid <= 0.
- clk_en=0: all state holds; out_valid clears.
- No wrap: the ACC_W check guarantees no overflow even with full-scale input for a whole window.
- Reset mid-window: the partial sum is lost and no output is produced.

Decomposition:
- Package dc_error_pkg: default IN_W/ACC_W/WIN_LOG2/NCH constants, CH_W helper function, signed sample/sum typedefs.
- Sub-module dc_err_round (combinational): adds the half-LSB, arithmetic-shifts by WIN_LOG2 and truncates to IN_W. It is used on the final-sample path.
- Per-channel state is held as arrays in the top module; the top module is not split further.

Test Plan:
1. NCH=4, WIN_LOG2=2; ch0 samples 1,2,3,4 -> out_valid 1 cycle after 4th sample, out_ch=0, err_sum=10, err_mean=3.
2. ch1 samples -1,-2,-3,-4 -> err_sum=-10, err_mean=-2 (round-half-up of -2.5).
3. Interleave ch0 (5,5,5,5) and ch3 (-7,-7,-7,-7) sample by sample -> two independent pulses: ch0 sum 20/mean 5, ch3 sum -28/mean -7.
4. ch2 receives 9,9; then clear_accum with simultaneous ch2 sample 5; then 1,1,1 -> single pulse with err_sum=8, err_mean=2.
5. Defaults (WIN_LOG2=10): 1024 samples of -131072 on ch0 -> err_sum=-134217728, err_mean=-131072, no wrap. Repeat with +131071 -> err_sum=134216704, err_mean=131071.
6. WIN_LOG2=2: ch=5 with clk_en -> chan_err=1, no state change; 2 ch0 samples, reset, 2 more ch0 samples -> no out_valid; clear_accum -> chan_err=0.

Source files
------------

// File: rtl/dc_error_pkg.sv
// Shared constants and types for the multi-channel DC-error accumulator.
package dc_error_pkg;

    localparam int unsigned DEF_IN_W     = 18;
    localparam int unsigned DEF_NCH      = 4;
    localparam int unsigned DEF_WIN_LOG2 = 10;
    localparam int unsigned DEF_ACC_W    = 38;

    // Channel-index width; a single channel still needs one bit.
    function automatic int unsigned ch_w(input int unsigned nch);
        return (nch <= 1) ? 32'd1 : 32'($clog2(nch));
    endfunction

    typedef logic signed [DEF_IN_W-1:0]  sample_t;
    typedef logic signed [DEF_ACC_W-1:0] sum_t;

endpackage

// File: rtl/dc_error_mc_if.sv
// Sample-in / window-result-out bundle of the DC-error accumulator.
interface dc_error_mc_if
    import dc_error_pkg::*;
#(
    parameter int unsigned IN_W  = DEF_IN_W,
    parameter int unsigned NCH   = DEF_NCH,
    parameter int unsigned ACC_W = DEF_ACC_W
);
    localparam int unsigned CH_W = ch_w(NCH);

    logic                    clk_en;
    logic                    clear_accum;
    logic [CH_W-1:0]         ch;
    logic signed [IN_W-1:0]  error;
    logic                    out_valid;
    logic [CH_W-1:0]         out_ch;
    logic signed [ACC_W-1:0] err_sum;
    logic signed [IN_W-1:0]  err_mean;
    logic                    chan_err;

    modport master (
        output clk_en, clear_accum, ch, error,
        input  out_valid, out_ch, err_sum, err_mean, chan_err
    );

    modport slave (
        input  clk_en, clear_accum, ch, error,
        output out_valid, out_ch, err_sum, err_mean, chan_err
    );

endinterface

// File: rtl/dc_err_round.sv
// Round-half-up mean of a window sum: add half an output LSB, arithmetic shift, truncate.
module dc_err_round
    import dc_error_pkg::*;
#(
    parameter int unsigned IN_W     = DEF_IN_W,
    parameter int unsigned WIN_LOG2 = DEF_WIN_LOG2,
    parameter int unsigned ACC_W    = DEF_ACC_W
) (
    input  logic signed [ACC_W-1:0] sum,
    output logic signed [IN_W-1:0]  mean_c
);

    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) << (WIN_LOG2 - 1);

    logic signed [ACC_W-1:0] biased_c;
    logic signed [ACC_W-1:0] shifted_c;

    // Headroom of ACC_W >= IN_W+WIN_LOG2 keeps the bias add from wrapping.
    assign biased_c  = sum + HALF;
    assign shifted_c = biased_c >>> WIN_LOG2;
    assign mean_c    = IN_W'(shifted_c);

endmodule

// File: rtl/dc_error_mc.sv
// Multi-channel windowed DC-error accumulator: per-channel sums over 2^WIN_LOG2 samples,
// emitting the full sum and rounded mean at each window end.
module dc_error_mc
    import dc_error_pkg::*;
#(
    parameter int unsigned IN_W     = DEF_IN_W,
    parameter int unsigned NCH      = DEF_NCH,
    parameter int unsigned WIN_LOG2 = DEF_WIN_LOG2,
    parameter int unsigned ACC_W    = DEF_ACC_W
) (
    input  logic          clk,
    input  logic          reset,
    dc_error_mc_if.slave  bus
);

    localparam int unsigned CH_W = ch_w(NCH);

    if (ACC_W < IN_W + WIN_LOG2) begin : g_acc_w_check
        $error("dc_error_mc: ACC_W must be at least IN_W + WIN_LOG2");
    end
    if (WIN_LOG2 < 1 || NCH < 1) begin : g_param_check
        $error("dc_error_mc: WIN_LOG2 and NCH must be at least 1");
    end

    logic signed [ACC_W-1:0] acc_q [NCH];
    logic signed [ACC_W-1:0] acc_d [NCH];
    logic [WIN_LOG2-1:0]     cnt_q [NCH];
    logic [WIN_LOG2-1:0]     cnt_d [NCH];

    logic                    out_valid_q, out_valid_d;
    logic [CH_W-1:0]         out_ch_q,    out_ch_d;
    logic signed [ACC_W-1:0] err_sum_q,   err_sum_d;
    logic signed [IN_W-1:0]  err_mean_q,  err_mean_d;
    logic                    chan_err_q,  chan_err_d;

    logic                    ch_ok_c;
    logic signed [ACC_W-1:0] sel_acc_c;
    logic [WIN_LOG2-1:0]     sel_cnt_c;
    logic signed [ACC_W-1:0] sample_ext_c;
    logic signed [ACC_W-1:0] sum_c;
    logic                    last_c;
    logic signed [IN_W-1:0]  mean_c;

    assign ch_ok_c = 32'(bus.ch) < NCH;

    // Mux the addressed channel's state; out-of-range indices select nothing.
    always_comb begin
        sel_acc_c = '0;
        sel_cnt_c = '0;
        for (int c = 0; c < int'(NCH); c++) begin
            if (CH_W'(c) == bus.ch) begin
                sel_acc_c = acc_q[c];
                sel_cnt_c = cnt_q[c];
            end
        end
    end

    assign sample_ext_c = ACC_W'(bus.error);
    assign sum_c        = sel_acc_c + sample_ext_c;
    assign last_c       = &sel_cnt_c;

    dc_err_round #(
        .IN_W     (IN_W),
        .WIN_LOG2 (WIN_LOG2),
        .ACC_W    (ACC_W)
    ) u_round (
        .sum    (sum_c),
        .mean_c (mean_c)
    );

    // Next state: clear_accum outranks normal accumulation and restarts every window.
    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = 1'b0;
        out_ch_d    = out_ch_q;
        err_sum_d   = err_sum_q;
        err_mean_d  = err_mean_q;
        chan_err_d  = chan_err_q;

        if (bus.clear_accum) begin
            chan_err_d = 1'b0;
            for (int c = 0; c < int'(NCH); c++) begin
                acc_d[c] = '0;
                cnt_d[c] = '0;
                if (bus.clk_en && ch_ok_c && CH_W'(c) == bus.ch) begin
                    acc_d[c] = sample_ext_c;
                    cnt_d[c] = WIN_LOG2'(1);
                end
            end
        end else if (bus.clk_en) begin
            if (!ch_ok_c) begin
                chan_err_d = 1'b1;
            end else begin
                for (int c = 0; c < int'(NCH); c++) begin
                    if (CH_W'(c) == bus.ch) begin
                        if (last_c) begin
                            acc_d[c] = '0;
                            cnt_d[c] = '0;
                        end else begin
                            acc_d[c] = sum_c;
                            cnt_d[c] = cnt_q[c] + WIN_LOG2'(1);
                        end
                    end
                end
                if (last_c) begin
                    out_valid_d = 1'b1;
                    out_ch_d    = bus.ch;
                    err_sum_d   = sum_c;
                    err_mean_d  = mean_c;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < int'(NCH); c++) begin
                acc_q[c] <= '0;
                cnt_q[c] <= '0;
            end
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            err_sum_q   <= '0;
            err_mean_q  <= '0;
            chan_err_q  <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            err_sum_q   <= err_sum_d;
            err_mean_q  <= err_mean_d;
            chan_err_q  <= chan_err_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.err_sum   = err_sum_q;
    assign bus.err_mean  = err_mean_q;
    assign bus.chan_err  = chan_err_q;

endmodule

// File: tb/tb_dc_error_mc.sv
// Bench for dc_error_mc: a short-window instance checked against a windowed-mean model,
// plus a default-size instance for full-scale windows.
module tb_dc_error_mc;

    localparam int NCH_A      = 5;
    localparam int WIN_LOG2_A = 2;
    localparam int WIN_A      = 4;
    localparam int ACC_W_A    = 20;

    logic clk;
    logic rst_a;
    logic rst_b;

    int n_checks;
    int n_fail;

    longint m_sum [NCH_A];
    int     m_cnt [NCH_A];
    bit     exp_valid;
    longint exp_sum;
    longint exp_mean;
    int     exp_ch;
    bit     exp_cerr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dc_error_mc_if #(.IN_W(18), .NCH(NCH_A), .ACC_W(ACC_W_A)) ifa ();
    dc_error_mc_if ifb ();

    dc_error_mc #(
        .IN_W(18), .NCH(NCH_A), .WIN_LOG2(WIN_LOG2_A), .ACC_W(ACC_W_A)
    ) u_dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (ifa.slave)
    );

    dc_error_mc u_dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (ifb.slave)
    );

    // Floor division, so the mean is floor((sum + n/2) / n), i.e. round half up.
    function automatic longint fdiv(input longint x, input longint n);
        if (x >= 0) return x / n;
        return -((-x + n - 1) / n);
    endfunction

    // One clock on instance A; the model applies the same edge's effect.
    task automatic step_a(input bit en, input bit clr, input bit rst, input int chv, input int errv);
        ifa.clk_en      = en;
        ifa.clear_accum = clr;
        ifa.ch          = 3'(chv);
        ifa.error       = 18'(errv);
        rst_a           = rst;
        @(posedge clk);
        #1;
        if (rst) begin
            for (int i = 0; i < NCH_A; i++) begin m_sum[i] = 0; m_cnt[i] = 0; end
            exp_valid = 0; exp_sum = 0; exp_mean = 0; exp_ch = 0; exp_cerr = 0;
        end else begin
            exp_valid = 0;
            if (clr) begin
                for (int i = 0; i < NCH_A; i++) begin m_sum[i] = 0; m_cnt[i] = 0; end
                exp_cerr = 0;
                if (en && chv < NCH_A) begin m_sum[chv] = errv; m_cnt[chv] = 1; end
            end else if (en) begin
                if (chv >= NCH_A) begin
                    exp_cerr = 1;
                end else begin
                    m_sum[chv] += longint'(errv);
                    m_cnt[chv] += 1;
                    if (m_cnt[chv] == WIN_A) begin
                        exp_valid = 1;
                        exp_sum   = m_sum[chv];
                        exp_mean  = fdiv(exp_sum + WIN_A / 2, WIN_A);
                        exp_ch    = chv;
                        m_sum[chv] = 0;
                        m_cnt[chv] = 0;
                    end
                end
            end
        end
    endtask

    task automatic step_b(input bit en, input int errv);
        ifb.clk_en      = en;
        ifb.clear_accum = 1'b0;
        ifb.ch          = '0;
        ifb.error       = 18'(errv);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        ifb.clk_en = 1'b0; ifb.clear_accum = 1'b0; ifb.ch = '0; ifb.error = '0;
        rst_b = 1'b1;
        step_a(0, 0, 1, 0, 0);
        step_a(1, 0, 1, 0, 77);
        n_checks += 6;
        if (ifa.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_a_valid got %b want 0", ifa.out_valid); end
        if (ifa.err_sum !== '0) begin n_fail++; $display("FAIL reset_a_sum got %0d want 0", ifa.err_sum); end
        if (ifa.err_mean !== '0 || ifa.out_ch !== '0) begin n_fail++; $display("FAIL reset_a_mean_ch got %0d/%0d want 0/0", ifa.err_mean, ifa.out_ch); end
        if (ifa.chan_err !== 1'b0) begin n_fail++; $display("FAIL reset_a_chan_err got %b want 0", ifa.chan_err); end
        if (ifb.out_valid !== 1'b0 || ifb.chan_err !== 1'b0) begin n_fail++; $display("FAIL reset_b_flags got %b/%b want 0/0", ifb.out_valid, ifb.chan_err); end
        if (ifb.err_sum !== '0 || ifb.err_mean !== '0) begin n_fail++; $display("FAIL reset_b_data got %0d/%0d want 0/0", ifb.err_sum, ifb.err_mean); end
        rst_b = 1'b0;
    endtask

    task automatic test_window(input string tag, input int chv, input int s[4], input longint es, input longint em);
        for (int i = 0; i < 4; i++) begin
            step_a(1, 0, 0, chv, s[i]);
            n_checks++;
            if (ifa.out_valid !== (i == 3)) begin n_fail++; $display("FAIL %s_valid step %0d got %b want %b", tag, i, ifa.out_valid, (i == 3)); end
        end
        n_checks += 3;
        if (longint'(ifa.err_sum) !== es) begin n_fail++; $display("FAIL %s_sum got %0d want %0d", tag, ifa.err_sum, es); end
        if (longint'(ifa.err_mean) !== em) begin n_fail++; $display("FAIL %s_mean got %0d want %0d", tag, ifa.err_mean, em); end
        if (int'(ifa.out_ch) !== chv) begin n_fail++; $display("FAIL %s_ch got %0d want %0d", tag, ifa.out_ch, chv); end
    endtask

    task automatic test_interleave();
        for (int i = 0; i < 8; i++) begin
            step_a(1, 0, 0, (i % 2) ? 3 : 0, (i % 2) ? -7 : 5);
            n_checks++;
            if (ifa.out_valid !== (i >= 6)) begin n_fail++; $display("FAIL interleave_valid step %0d got %b want %b", i, ifa.out_valid, (i >= 6)); end
            if (i == 6) begin
                n_checks++;
                if (ifa.out_ch !== 3'd0 || longint'(ifa.err_sum) !== 20 || longint'(ifa.err_mean) !== 5) begin
                    n_fail++; $display("FAIL interleave_ch0 got ch%0d %0d/%0d want ch0 20/5", ifa.out_ch, ifa.err_sum, ifa.err_mean);
                end
            end
            if (i == 7) begin
                n_checks++;
                if (ifa.out_ch !== 3'd3 || longint'(ifa.err_sum) !== -28 || longint'(ifa.err_mean) !== -7) begin
                    n_fail++; $display("FAIL interleave_ch3 got ch%0d %0d/%0d want ch3 -28/-7", ifa.out_ch, ifa.err_sum, ifa.err_mean);
                end
            end
        end
    endtask

    task automatic test_clear();
        int clr_t [6] = '{0, 0, 1, 0, 0, 0};
        int val_t [6] = '{9, 9, 5, 1, 1, 1};
        for (int i = 0; i < 6; i++) begin
            step_a(1, clr_t[i] != 0, 0, 2, val_t[i]);
            n_checks++;
            if (ifa.out_valid !== (i == 5)) begin n_fail++; $display("FAIL clear_valid step %0d got %b want %b", i, ifa.out_valid, (i == 5)); end
        end
        n_checks++;
        if (ifa.out_ch !== 3'd2 || longint'(ifa.err_sum) !== 8 || longint'(ifa.err_mean) !== 2) begin
            n_fail++; $display("FAIL clear_result got ch%0d %0d/%0d want ch2 8/2", ifa.out_ch, ifa.err_sum, ifa.err_mean);
        end
    endtask

    task automatic test_bad_channel();
        step_a(1, 0, 0, 5, 1000);
        n_checks++;
        if (ifa.chan_err !== 1'b1 || ifa.out_valid !== 1'b0) begin n_fail++; $display("FAIL bad_ch_flag got %b/%b want 1/0", ifa.chan_err, ifa.out_valid); end
        for (int i = 0; i < 5; i++) begin
            step_a(i != 2, 0, i == 2, 0, 7);
            n_checks++;
            if (ifa.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mid_window_valid step %0d got %b want 0", i, ifa.out_valid); end
        end
        n_checks++;
        if (ifa.chan_err !== 1'b0) begin n_fail++; $display("FAIL reset_chan_err got %b want 0", ifa.chan_err); end
        step_a(1, 0, 0, 6, 1);
        step_a(0, 1, 0, 0, 0);
        n_checks++;
        if (ifa.chan_err !== 1'b0 || ifa.out_valid !== 1'b0) begin n_fail++; $display("FAIL clear_chan_err got %b/%b want 0/0", ifa.chan_err, ifa.out_valid); end
        step_a(1, 0, 0, 7, 999);
        test_window("bad_ch_no_effect", 1, '{10, 20, 30, 40}, 100, 25);
        n_checks++;
        if (ifa.chan_err !== 1'b1) begin n_fail++; $display("FAIL bad_ch_sticky got %b want 1", ifa.chan_err); end
    endtask

    task automatic test_back_to_back();
        step_a(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step_a(1, 0, 0, 1, 1);
            step_a(1, 0, 0, 2, 2);
        end
        step_a(1, 0, 0, 1, 1);
        n_checks++;
        if (ifa.out_valid !== 1'b1 || ifa.out_ch !== 3'd1 || longint'(ifa.err_sum) !== 4 || longint'(ifa.err_mean) !== 1) begin
            n_fail++; $display("FAIL b2b_first got v%b ch%0d %0d/%0d want v1 ch1 4/1", ifa.out_valid, ifa.out_ch, ifa.err_sum, ifa.err_mean);
        end
        step_a(1, 0, 0, 2, 2);
        n_checks++;
        if (ifa.out_valid !== 1'b1 || ifa.out_ch !== 3'd2 || longint'(ifa.err_sum) !== 8 || longint'(ifa.err_mean) !== 2) begin
            n_fail++; $display("FAIL b2b_second got v%b ch%0d %0d/%0d want v1 ch2 8/2", ifa.out_valid, ifa.out_ch, ifa.err_sum, ifa.err_mean);
        end
        step_a(0, 0, 0, 2, 3);
        n_checks++;
        if (ifa.out_valid !== 1'b0 || ifa.out_ch !== 3'd2 || longint'(ifa.err_sum) !== 8) begin
            n_fail++; $display("FAIL b2b_hold got v%b ch%0d %0d want v0 ch2 8", ifa.out_valid, ifa.out_ch, ifa.err_sum);
        end
    endtask

    task automatic test_random();
        step_a(0, 1, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            bit en;
            bit clr;
            int chv;
            int v;
            en  = ($urandom_range(0, 9) < 8);
            clr = ($urandom_range(0, 49) == 0);
            chv = int'($urandom_range(0, 7));
            v   = int'($urandom_range(0, 262143)) - 131072;
            step_a(en, clr, 0, chv, v);
            n_checks += 3;
            if (ifa.out_valid !== exp_valid || ifa.chan_err !== exp_cerr) begin
                n_fail++; $display("FAIL random_flags cyc %0d got v%b e%b want v%b e%b", i, ifa.out_valid, ifa.chan_err, exp_valid, exp_cerr);
            end
            if (longint'(ifa.err_sum) !== exp_sum || int'(ifa.out_ch) !== exp_ch) begin
                n_fail++; $display("FAIL random_sum cyc %0d got ch%0d %0d want ch%0d %0d", i, ifa.out_ch, ifa.err_sum, exp_ch, exp_sum);
            end
            if (longint'(ifa.err_mean) !== exp_mean) begin
                n_fail++; $display("FAIL random_mean cyc %0d got %0d want %0d", i, ifa.err_mean, exp_mean);
            end
        end
    endtask

    task automatic test_full_scale();
        int     vals [2]  = '{-131072, 131071};
        longint sums [2]  = '{-134217728, 134216704};
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 1024; i++) begin
                step_b(1, vals[r]);
                if (i == 1022) begin
                    n_checks++;
                    if (ifb.out_valid !== 1'b0) begin n_fail++; $display("FAIL full_scale_early rep %0d got %b want 0", r, ifb.out_valid); end
                end
            end
            n_checks += 3;
            if (ifb.out_valid !== 1'b1 || ifb.out_ch !== 2'd0) begin n_fail++; $display("FAIL full_scale_valid rep %0d got v%b ch%0d want v1 ch0", r, ifb.out_valid, ifb.out_ch); end
            if (longint'(ifb.err_sum) !== sums[r]) begin n_fail++; $display("FAIL full_scale_sum rep %0d got %0d want %0d", r, ifb.err_sum, sums[r]); end
            if (longint'(ifb.err_mean) !== fdiv(sums[r] + 512, 1024)) begin n_fail++; $display("FAIL full_scale_mean rep %0d got %0d want %0d", r, ifb.err_mean, fdiv(sums[r] + 512, 1024)); end
            step_b(0, 0);
            n_checks++;
            if (ifb.out_valid !== 1'b0 || longint'(ifb.err_sum) !== sums[r]) begin n_fail++; $display("FAIL full_scale_hold rep %0d got v%b %0d want v0 %0d", r, ifb.out_valid, ifb.err_sum, sums[r]); end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_window("basic_pos", 0, '{1, 2, 3, 4}, 10, 3);
        test_window("basic_neg", 1, '{-1, -2, -3, -4}, -10, -2);
        test_interleave();
        test_clear();
        test_bad_channel();
        test_back_to_back();
        test_random();
        test_full_scale();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
